// File: rtl/frame_uart_sched.sv
// Streams the downsampled frame buffer over the debug UART: a 2-byte sync header,
// then every buffer word MSB-first (x inner, y outer), then a mod-256 sum checksum.
module frame_uart_sched #(
  parameter int          COLS    = 40,
  parameter int          ROWS    = 30,
  parameter int          XW      = 6,
  parameter int          YW      = 5,
  parameter int          HOLDOFF = 8191,
  parameter logic [7:0]  HDR0    = 8'h55,
  parameter logic [7:0]  HDR1    = 8'hAA
) (
  input  logic          sys_clk_i,
  input  logic          areset_n,
  input  logic          start_i,
  input  logic          continuous_i,
  output logic [XW-1:0] read_x,
  output logic [YW-1:0] read_y,
  input  logic [31:0]   read_q,
  input  logic          uart_busy,
  output logic          uart_wr,
  output logic [7:0]    uart_dat,
  output logic          busy_o,
  output logic          frame_done,
  output logic [7:0]    frame_count
);

  localparam int            HW       = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);
  localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_H0,
    S_H1,
    S_DATA,
    S_CSUM
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_z;
  logic          r_wr;
  logic [7:0]    r_dat;
  logic          r_done;
  logic [7:0]    r_fcnt;
  logic [7:0]    r_csum;
  logic [HW-1:0] r_hold;

  logic          w_wr;
  logic          w_last;
  logic          w_clr;
  logic [7:0]    w_byte;

  function automatic logic [7:0] sel_byte(input logic [31:0] q, input logic [1:0] z);
    logic [7:0] b;
    unique case (z)
      2'd0:    b = q[31:24];
      2'd1:    b = q[23:16];
      2'd2:    b = q[15:8];
      default: b = q[7:0];
    endcase
    return b;
  endfunction

  // A byte may go out only after the UART has been idle for a full holdoff window,
  // and never in the cycle right after a strobe (uart_busy lags uart_wr by one cycle).
  assign w_wr   = (r_state != S_IDLE) && (r_hold == HOLD_MAX) && !uart_busy && !r_wr;
  assign w_last = (r_z == 2'd3) && (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge sys_clk_i or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte      = 8'h00;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_H0;
          w_clr       = 1'b1;
        end
      end
      S_H0: begin
        w_byte = HDR0;
        if (w_wr) w_state_nxt = S_H1;
      end
      S_H1: begin
        w_byte = HDR1;
        if (w_wr) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_byte = sel_byte(read_q, r_z);
        if (w_wr && w_last) w_state_nxt = S_CSUM;
      end
      S_CSUM: begin
        w_byte = r_csum;
        if (w_wr) begin
          if (continuous_i) begin
            w_state_nxt = S_H0;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge areset_n) begin
    if (!areset_n) begin
      r_wr   <= 1'b0;
      r_dat  <= 8'h00;
      r_done <= 1'b0;
      r_fcnt <= 8'h00;
      r_hold <= '0;
    end else begin
      r_wr   <= w_wr;
      r_done <= w_wr && (r_state == S_CSUM);
      if (w_wr) r_dat <= w_byte;
      if (w_wr && (r_state == S_CSUM)) r_fcnt <= r_fcnt + 8'd1;
      if (uart_busy || r_wr) begin
        r_hold <= '0;
      end else if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  // Address advances in the write cycle of the last byte of a word; the holdoff
  // window leaves the synchronous RAM ample time to present the next word.
  always_ff @(posedge sys_clk_i or negedge areset_n) begin
    if (!areset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= 2'd0;
      r_csum <= 8'h00;
    end else if (w_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= 2'd0;
      r_csum <= 8'h00;
    end else if (w_wr && (r_state == S_DATA)) begin
      r_csum <= r_csum + w_byte;
      r_z    <= r_z + 2'd1;
      if (r_z == 2'd3) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  assign read_x      = r_x;
  assign read_y      = r_y;
  assign uart_wr     = r_wr;
  assign uart_dat    = r_dat;
  assign busy_o      = (r_state != S_IDLE);
  assign frame_done  = r_done;
  assign frame_count = r_fcnt;

endmodule
